// File: rtl/ps2_pkg.sv
// PS/2 key decoder shared definitions.
// Holds the scan-code prefix constants, the pause skip count, the decoder
// state encoding and the 10-bit key event record {ext, brk, code}.
// Contents: PS2_EXT, PS2_BRK, PS2_PAUSE, PS2_ERR0, PS2_ERR1, PAUSE_SKIP,
//           state_t, ps2_event_t, is_prefix().
package ps2_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;
  localparam logic [7:0] PS2_ERR0   = 8'h00;
  localparam logic [7:0] PS2_ERR1   = 8'hFF;
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXT     = 3'd1,
    ST_BRK     = 3'd2,
    ST_EXT_BRK = 3'd3,
    ST_PAUSE   = 3'd4
  } state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;

  // True for any byte that starts or modifies a multi-byte sequence.
  function automatic logic is_prefix(input logic [7:0] b);
    return (b == PS2_EXT) || (b == PS2_BRK) || (b == PS2_PAUSE);
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Key event handshake bundle between the decoder and its consumer.
// Signals: ev_valid (head event available), ev_ready (consumer takes head),
//          ev_code / ev_ext / ev_brk (head event fields).
// Modports: master = decoder side, slave = consumer side.
interface ps2_key_decoder_if;

  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_brk;

  modport master (output ev_valid, ev_code, ev_ext, ev_brk, input ev_ready);
  modport slave  (input ev_valid, ev_code, ev_ext, ev_brk, output ev_ready);

endinterface

// File: rtl/ps2_event_fifo.sv
// Key event buffer: DEPTH-entry circular FIFO of ps2_event_t records.
// Ports: clk, clr (async active-high reset), push/din (write), pop (read),
//        dout (head entry), full, empty, level (entries stored, 0..DEPTH).
// A pop while empty is ignored; a push while full is accepted only when a
// pop happens in the same cycle, otherwise it is dropped by the caller's
// overflow accounting. DEPTH=1 degenerates to a single holding register.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       push,
  input  ps2_event_t din,
  input  logic       pop,
  output ps2_event_t dout,
  output logic       full,
  output logic       empty,
  output logic [4:0] level
);

  localparam int             AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0]  LAST    = AW'(DEPTH - 1);
  localparam logic [4:0]     LVL_MAX = 5'(DEPTH);

  ps2_event_t    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [4:0]    level_r;
  logic          do_pop_s;
  logic          do_push_s;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST) ? '0 : p + AW'(1);
  endfunction

  assign empty     = (level_r == 5'd0);
  assign full      = (level_r == LVL_MAX);
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);
  assign dout      = mem_r[rd_ptr_r];
  assign level     = level_r;

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= 5'd0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (do_pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   level_r <= level_r + 5'd1;
        2'b01:   level_r <= level_r - 5'd1;
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code set 2 decoder with buffered key events.
// Ports: clk, clr (async active-high reset), rx_valid/rx_data (received
//        bytes), stat_clr (clears ovf/err), ev (event handshake, master),
//        fifo_level (events stored), ovf (sticky drop flag),
//        err (sticky protocol error flag).
// Build option: PS2_KEYFIFO_EN defined -> FIFO_DEPTH-entry event FIFO;
//               undefined -> single holding register (depth 1).
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_data,
  input  logic                     stat_clr,
  ps2_key_decoder_if.master        ev,
  output logic [4:0]               fifo_level,
  output logic                     ovf,
  output logic                     err
);

`ifdef PS2_KEYFIFO_EN
  localparam int BUF_DEPTH = FIFO_DEPTH;
`else
  // FIFO_DEPTH is still accepted so both builds share one parameter list.
  localparam int BUF_DEPTH = (FIFO_DEPTH > 0) ? 1 : 1;
`endif

  state_t     state_r;
  state_t     state_nxt_s;
  logic [2:0] skip_r;
  logic [2:0] skip_nxt_s;
  logic       emit_s;
  logic       err_hit_s;
  logic       ovf_hit_s;
  ps2_event_t ev_s;
  ps2_event_t head_s;
  logic       buf_full_s;
  logic       buf_empty_s;
  logic       err_r;
  logic       ovf_r;

  // Byte decode: next state, skip count, event to emit and error detection.
  always_comb begin
    state_nxt_s = state_r;
    skip_nxt_s  = skip_r;
    emit_s      = 1'b0;
    err_hit_s   = 1'b0;
    ev_s.ext    = 1'b0;
    ev_s.brk    = 1'b0;
    ev_s.code   = rx_data;
    if (rx_valid) begin
      case (state_r)
        ST_IDLE: begin
          if (rx_data == PS2_EXT) begin
            state_nxt_s = ST_EXT;
          end else if (rx_data == PS2_BRK) begin
            state_nxt_s = ST_BRK;
          end else if (rx_data == PS2_PAUSE) begin
            state_nxt_s = ST_PAUSE;
            skip_nxt_s  = PAUSE_SKIP;
          end else if ((rx_data == PS2_ERR0) || (rx_data == PS2_ERR1)) begin
            err_hit_s = 1'b1;
          end else begin
            emit_s = 1'b1;
          end
        end
        ST_EXT: begin
          if (rx_data == PS2_BRK) begin
            state_nxt_s = ST_EXT_BRK;
          end else if (rx_data == PS2_EXT) begin
            state_nxt_s = ST_EXT;
          end else begin
            emit_s      = 1'b1;
            ev_s.ext    = 1'b1;
            state_nxt_s = ST_IDLE;
          end
        end
        ST_BRK, ST_EXT_BRK: begin
          state_nxt_s = ST_IDLE;
          if (is_prefix(rx_data)) begin
            err_hit_s = 1'b1;
          end else begin
            emit_s   = 1'b1;
            ev_s.ext = (state_r == ST_EXT_BRK);
            ev_s.brk = 1'b1;
          end
        end
        ST_PAUSE: begin
          // The pause sequence is swallowed whole; only its end is reported.
          skip_nxt_s = skip_r - 3'd1;
          if (skip_r == 3'd1) begin
            emit_s      = 1'b1;
            ev_s.code   = PS2_PAUSE;
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_PAUSE;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          skip_nxt_s  = 3'd0;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
      skip_nxt_s  = skip_r;
    end
  end

  // A drop happens only when full and the consumer is not freeing a slot.
  assign ovf_hit_s = emit_s & buf_full_s & ~ev.ev_ready;

  // Decoder state and sticky status flags; a new set beats stat_clr.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r <= ST_IDLE;
      skip_r  <= 3'd0;
      err_r   <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      skip_r  <= skip_nxt_s;
      err_r   <= err_hit_s ? 1'b1 : (stat_clr ? 1'b0 : err_r);
      ovf_r   <= ovf_hit_s ? 1'b1 : (stat_clr ? 1'b0 : ovf_r);
    end
  end

  ps2_event_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .clr   (clr),
    .push  (emit_s),
    .din   (ev_s),
    .pop   (ev.ev_ready),
    .dout  (head_s),
    .full  (buf_full_s),
    .empty (buf_empty_s),
    .level (fifo_level)
  );

  assign ev.ev_valid = ~buf_empty_s;
  assign ev.ev_code  = head_s.code;
  assign ev.ev_ext   = head_s.ext;
  assign ev.ev_brk   = head_s.brk;
  assign err         = err_r;
  assign ovf         = ovf_r;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: reset state, table-driven decode
// vectors, hand-written pause / overflow / reset-mid-prefix / flag-priority
// sequences, and randomized traffic checked against a prefix-flag model.
module tb_ps2_key_decoder;
  import ps2_pkg::*;

  localparam int FIFO_DEPTH = 4;
`ifdef PS2_KEYFIFO_EN
  localparam int EFF_DEPTH = FIFO_DEPTH;
`else
  localparam int EFF_DEPTH = 1;
`endif

  logic       clk = 1'b0;
  logic       clr;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       stat_clr;
  logic [4:0] fifo_level;
  logic       ovf;
  logic       err;

  ps2_key_decoder_if ev ();

  ps2_key_decoder #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk        (clk),
    .clr        (clr),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .stat_clr   (stat_clr),
    .ev         (ev.master),
    .fifo_level (fifo_level),
    .ovf        (ovf),
    .err        (err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: pending prefix flags, pause byte countdown, event queue.
  logic [9:0] mq[$];
  bit         m_ext;
  bit         m_brk;
  int         m_skip;
  bit         m_ovf;
  bit         m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ext  = 1'b0;
    m_brk  = 1'b0;
    m_skip = 0;
    m_ovf  = 1'b0;
    m_err  = 1'b0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] d, input bit rdy, input bit sc);
    bit         do_pop;
    bit         emit;
    bit         err_hit;
    bit         ovf_hit;
    logic [9:0] e;
    do_pop  = rdy && (mq.size() > 0);
    emit    = 1'b0;
    err_hit = 1'b0;
    ovf_hit = 1'b0;
    e       = '0;
    if (v) begin
      if (m_skip > 0) begin
        m_skip--;
        if (m_skip == 0) begin
          emit = 1'b1;
          e    = {1'b0, 1'b0, 8'hE1};
        end
      end else if (d == 8'hE1 && !m_ext && !m_brk) begin
        m_skip = 7;
      end else if (m_brk) begin
        if (d == 8'hE0 || d == 8'hF0 || d == 8'hE1) begin
          err_hit = 1'b1;
        end else begin
          emit = 1'b1;
          e    = {m_ext, 1'b1, d};
        end
        m_ext = 1'b0;
        m_brk = 1'b0;
      end else if (d == 8'hF0) begin
        m_brk = 1'b1;
      end else if (d == 8'hE0) begin
        m_ext = 1'b1;
      end else if (!m_ext && (d == 8'h00 || d == 8'hFF)) begin
        err_hit = 1'b1;
      end else begin
        emit  = 1'b1;
        e     = {m_ext, 1'b0, d};
        m_ext = 1'b0;
      end
    end
    if (do_pop) void'(mq.pop_front());
    if (emit) begin
      if (mq.size() < EFF_DEPTH) mq.push_back(e);
      else ovf_hit = 1'b1;
    end
    m_err = err_hit ? 1'b1 : (sc ? 1'b0 : m_err);
    m_ovf = ovf_hit ? 1'b1 : (sc ? 1'b0 : m_ovf);
  endtask

  // One clock: drive inputs, advance the model at the edge, settle 1 time unit.
  task automatic cycle(input bit v, input logic [7:0] d, input bit rdy, input bit sc);
    rx_valid    = v;
    rx_data     = d;
    ev.ev_ready = rdy;
    stat_clr    = sc;
    @(posedge clk);
    model_step(v, d, rdy, sc);
    #1;
    rx_valid    = 1'b0;
    ev.ev_ready = 1'b0;
    stat_clr    = 1'b0;
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_reset();
  endtask

  task automatic check_model(input string tag);
    chk({tag, " valid"}, {31'd0, ev.ev_valid}, {31'd0, mq.size() > 0});
    chk({tag, " level"}, {27'd0, fifo_level}, mq.size());
    chk({tag, " ovf"}, {31'd0, ovf}, {31'd0, m_ovf});
    chk({tag, " err"}, {31'd0, err}, {31'd0, m_err});
    if (mq.size() > 0) begin
      chk({tag, " head"}, {22'd0, ev.ev_ext, ev.ev_brk, ev.ev_code}, {22'd0, mq[0]});
    end
  endtask

  typedef struct {
    bit         v;
    logic [7:0] d;
    bit         rdy;
    bit         sc;
    bit         e_valid;
    logic [7:0] e_code;
    bit         e_ext;
    bit         e_brk;
    int         e_lvl;
    bit         e_err;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit v, input logic [7:0] d, input bit rdy, input bit sc,
                     input bit e_valid, input logic [7:0] e_code, input bit e_ext,
                     input bit e_brk, input int e_lvl, input bit e_err);
    vec_t t;
    t.v = v; t.d = d; t.rdy = rdy; t.sc = sc;
    t.e_valid = e_valid; t.e_code = e_code; t.e_ext = e_ext; t.e_brk = e_brk;
    t.e_lvl = e_lvl; t.e_err = e_err;
    tbl.push_back(t);
  endtask

  logic [7:0] codes [5];

  initial begin
    clr = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; stat_clr = 1'b0; ev.ev_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    clr = 1'b0;

    // Reset state
    chk("reset valid", {31'd0, ev.ev_valid}, 32'd0);
    chk("reset code", {24'd0, ev.ev_code}, 32'd0);
    chk("reset ext_brk", {30'd0, ev.ev_ext, ev.ev_brk}, 32'd0);
    chk("reset level", {27'd0, fifo_level}, 32'd0);
    chk("reset flags", {30'd0, ovf, err}, 32'd0);

    //  v  data   rdy sc  valid code  ext brk lvl err
    add(1, 8'h1C, 0, 0,  1, 8'h1C, 0, 0, 1, 0);
    add(0, 8'h00, 1, 0,  0, 8'h00, 0, 0, 0, 0);
    add(1, 8'hF0, 0, 0,  0, 8'h00, 0, 0, 0, 0);
    add(1, 8'h1C, 0, 0,  1, 8'h1C, 0, 1, 1, 0);
    add(0, 8'h00, 1, 0,  0, 8'h00, 0, 0, 0, 0);
    add(1, 8'hE0, 0, 0,  0, 8'h00, 0, 0, 0, 0);
    add(1, 8'h75, 0, 0,  1, 8'h75, 1, 0, 1, 0);
    add(0, 8'h00, 1, 0,  0, 8'h00, 0, 0, 0, 0);
    add(1, 8'hE0, 0, 0,  0, 8'h00, 0, 0, 0, 0);
    add(1, 8'hF0, 0, 0,  0, 8'h00, 0, 0, 0, 0);
    add(1, 8'h75, 0, 0,  1, 8'h75, 1, 1, 1, 0);
    add(0, 8'h00, 1, 0,  0, 8'h00, 0, 0, 0, 0);
    add(1, 8'hF0, 0, 0,  0, 8'h00, 0, 0, 0, 0);
    add(1, 8'hE0, 0, 0,  0, 8'h00, 0, 0, 0, 1);
    add(1, 8'h1C, 0, 0,  1, 8'h1C, 0, 0, 1, 1);
    add(0, 8'h00, 1, 1,  0, 8'h00, 0, 0, 0, 0);
    add(1, 8'h2A, 0, 0,  1, 8'h2A, 0, 0, 1, 0);
    add(0, 8'h00, 0, 0,  1, 8'h2A, 0, 0, 1, 0);
    add(0, 8'h00, 1, 0,  0, 8'h00, 0, 0, 0, 0);
    add(0, 8'h00, 1, 0,  0, 8'h00, 0, 0, 0, 0);
    add(1, 8'h33, 0, 0,  1, 8'h33, 0, 0, 1, 0);
    add(1, 8'h44, 1, 0,  1, 8'h44, 0, 0, 1, 0);
    add(0, 8'h00, 1, 0,  0, 8'h00, 0, 0, 0, 0);
    add(1, 8'h00, 0, 0,  0, 8'h00, 0, 0, 0, 1);
    add(0, 8'h00, 0, 1,  0, 8'h00, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].rdy, tbl[i].sc);
      chk($sformatf("vec%0d valid", i), {31'd0, ev.ev_valid}, {31'd0, tbl[i].e_valid});
      chk($sformatf("vec%0d level", i), {27'd0, fifo_level}, tbl[i].e_lvl);
      chk($sformatf("vec%0d err", i), {31'd0, err}, {31'd0, tbl[i].e_err});
      chk($sformatf("vec%0d ovf", i), {31'd0, ovf}, 32'd0);
      if (tbl[i].e_valid) begin
        chk($sformatf("vec%0d head", i), {22'd0, ev.ev_ext, ev.ev_brk, ev.ev_code},
            {22'd0, tbl[i].e_ext, tbl[i].e_brk, tbl[i].e_code});
      end
    end

    // Pause sequence yields exactly one E1 event and no error
    codes[0] = 8'h00;
    begin
      logic [7:0] pseq [8];
      pseq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
      for (int i = 0; i < 7; i++) begin
        cycle(1'b1, pseq[i], 1'b0, 1'b0);
        chk($sformatf("pause byte%0d no event", i), {31'd0, ev.ev_valid}, 32'd0);
      end
      cycle(1'b1, pseq[7], 1'b0, 1'b0);
      chk("pause event", {21'd0, ev.ev_valid, ev.ev_ext, ev.ev_brk, ev.ev_code}, {21'd0, 1'b1, 2'b00, 8'hE1});
      chk("pause err", {31'd0, err}, 32'd0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      chk("pause single event", {27'd0, fifo_level}, 32'd0);
    end

    // Overflow: five makes with consumer stalled
    codes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};
    for (int i = 0; i < 5; i++) cycle(1'b1, codes[i], 1'b0, 1'b0);
    chk("ovf level", {27'd0, fifo_level}, EFF_DEPTH);
    chk("ovf flag", {31'd0, ovf}, 32'd1);
    for (int i = 0; i < EFF_DEPTH; i++) begin
      chk($sformatf("ovf order%0d", i), {23'd0, ev.ev_valid, ev.ev_code}, {23'd0, 1'b1, codes[i]});
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("ovf drained", {27'd0, fifo_level}, 32'd0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf cleared", {31'd0, ovf}, 32'd0);

    // Error set wins over a same-cycle stat_clr
    cycle(1'b1, 8'hF0, 1'b0, 1'b0);
    cycle(1'b1, 8'hE1, 1'b0, 1'b1);
    chk("err set priority", {31'd0, err}, 32'd1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk("err cleared", {31'd0, err}, 32'd0);

    // Reset in the middle of an E0 prefix
    cycle(1'b1, 8'hE0, 1'b0, 1'b0);
    do_clr();
    chk("midclr empty", {26'd0, ev.ev_valid, fifo_level}, 32'd0);
    cycle(1'b1, 8'h1C, 1'b0, 1'b0);
    chk("midclr decode", {21'd0, ev.ev_valid, ev.ev_ext, ev.ev_brk, ev.ev_code}, {21'd0, 1'b1, 2'b00, 8'h1C});
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int         r;
      logic [7:0] b;
      r = $urandom_range(0, 11);
      case (r)
        0: b = 8'hE0;
        1: b = 8'hF0;
        2: b = 8'hE1;
        3: b = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
        default: b = 8'($urandom_range(1, 254));
      endcase
      if ($urandom_range(0, 599) == 0) begin
        do_clr();
      end
      cycle($urandom_range(0, 1) == 1, b, $urandom_range(0, 9) < 4, $urandom_range(0, 19) == 0);
      check_model($sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
